// File: rtl/color_sensor.sv
// Colour-sensor front end: counts rising edges of two async sensor clocks per gate window, flags the faster one.
// Latency: input edge to count 3 clk; color updates on the clk after the window-end compare.
// No backpressure: free-running measurement, outputs are plain registered levels.
module color_sensor #(
   parameter int         GATE_CYCLES = 16777216,
   parameter int         CNT_W       = 16,
   parameter logic [1:0] SCALE       = 2'b11
) (
   output logic       color,
   output logic [1:0] scale,
   input  logic       sensorFreq,
   input  logic       sensorFreq2,
   input  logic       clk,
   input  logic       rst
);

   localparam int               TW      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [TW-1:0]    LAST    = TW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // bit 0 = sensorFreq (channel 1), bit 1 = sensorFreq2 (channel 2)
   logic [1:0]       r_meta;
   logic [1:0]       r_sync;
   logic [1:0]       r_prev;
   logic [TW-1:0]    r_timer;
   logic [CNT_W-1:0] r_cnt1;
   logic [CNT_W-1:0] r_cnt2;
   logic             r_color;
   logic [1:0]       r_scale;

   logic [1:0]       w_edge;
   logic             w_win_end;
   logic [CNT_W-1:0] w_cnt1_nxt;
   logic [CNT_W-1:0] w_cnt2_nxt;

   assign w_edge    = r_sync & ~r_prev;
   assign w_win_end = (r_timer == LAST);

   // Next counts include an edge seen this cycle, so the window-end compare sees it too.
   assign w_cnt1_nxt = (w_edge[0] && (r_cnt1 != CNT_MAX)) ? r_cnt1 + 1'b1 : r_cnt1;
   assign w_cnt2_nxt = (w_edge[1] && (r_cnt2 != CNT_MAX)) ? r_cnt2 + 1'b1 : r_cnt2;

   // Two-flop synchroniser plus a delayed copy for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 2'b00;
         r_sync <= 2'b00;
         r_prev <= 2'b00;
      end else begin
         r_meta <= {sensorFreq2, sensorFreq};
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   // Gate timer: 0..GATE_CYCLES-1, wrapping at window end.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timer <= '0;
      end else if (w_win_end) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + 1'b1;
      end
   end

   // Saturating edge counters; zero going into the next window so its first edge counts as 1.
   always_ff @(posedge clk) begin
      if (rst || w_win_end) begin
         r_cnt1 <= '0;
         r_cnt2 <= '0;
      end else begin
         r_cnt1 <= w_cnt1_nxt;
         r_cnt2 <= w_cnt2_nxt;
      end
   end

   // Colour decision at window end; a tie keeps the previous decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_color <= 1'b0;
      end else if (w_win_end) begin
         if (w_cnt1_nxt > w_cnt2_nxt) begin
            r_color <= 1'b1;
         end else if (w_cnt2_nxt > w_cnt1_nxt) begin
            r_color <= 1'b0;
         end
      end
   end

   // Sensor held in power-down during reset, then the configured output scaling.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scale <= 2'b00;
      end else begin
         r_scale <= SCALE;
      end
   end

   assign color = r_color;
   assign scale = r_scale;

endmodule

// File: tb/tb_color_sensor.sv
// Directed bench for color_sensor: two instances (16-bit and 4-bit counters) share clock, reset and sensor inputs.
// Window length 1000 clk; stimulus changes only on window boundaries so every count is exact.
// Sensor waves are derived from one phase counter, so both channels stay phase-locked.
module tb_color_sensor;

   localparam int GATE = 1000;

   logic       clk;
   logic       rst;
   logic       sf1;
   logic       sf2;
   logic       color_a;
   logic [1:0] scale_a;
   logic       color_b;
   logic [1:0] scale_b;

   int per1;
   int per2;
   int ph;
   int checks;
   int errors;

   typedef struct {
      int   per1;
      int   per2;
      logic exp_a;
      logic exp_b;
   } vec_t;

   vec_t vecs[10];

   color_sensor #(.GATE_CYCLES(GATE), .CNT_W(16), .SCALE(2'b11)) u_dut (
      .color       (color_a),
      .scale       (scale_a),
      .sensorFreq  (sf1),
      .sensorFreq2 (sf2),
      .clk         (clk),
      .rst         (rst)
   );

   color_sensor #(.GATE_CYCLES(GATE), .CNT_W(4), .SCALE(2'b10)) u_sat (
      .color       (color_b),
      .scale       (scale_b),
      .sensorFreq  (sf1),
      .sensorFreq2 (sf2),
      .clk         (clk),
      .rst         (rst)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // period 0 = stuck low, 1 = stuck high, otherwise high for the first half of each period
   function automatic logic wave(input int per, input int p);
      if (per == 0) return 1'b0;
      if (per == 1) return 1'b1;
      return ((p % per) < (per / 2));
   endfunction

   task automatic set_rates(input int p1, input int p2);
      per1 = p1;
      per2 = p2;
      ph   = 0;
      sf1  = wave(p1, 0);
      sf2  = wave(p2, 0);
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         ph  = ph + 1;
         sf1 = wave(per1, ph);
         sf2 = wave(per2, ph);
      end
   endtask

   task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      per1   = 0;
      per2   = 0;
      ph     = 0;
      sf1    = 1'b0;
      sf2    = 1'b0;

      // Expected counts per window (16-bit / 4-bit):
      // P20 -> 50 / 15, P40 -> 25 / 15, P4 -> 250 / 15, P6 -> 167 / 15, stuck -> 0 (1 if it rises at the boundary)
      vecs[0] = '{per1: 20, per2: 40, exp_a: 1'b1, exp_b: 1'b0}; // 50>25 ; 15=15 hold 0
      vecs[1] = '{per1: 20, per2: 20, exp_a: 1'b1, exp_b: 1'b0}; // tie, hold
      vecs[2] = '{per1: 20, per2: 20, exp_a: 1'b1, exp_b: 1'b0};
      vecs[3] = '{per1: 20, per2: 20, exp_a: 1'b1, exp_b: 1'b0};
      vecs[4] = '{per1: 40, per2: 20, exp_a: 1'b0, exp_b: 1'b0}; // 25<50 ; tie
      vecs[5] = '{per1: 40, per2: 20, exp_a: 1'b0, exp_b: 1'b0};
      vecs[6] = '{per1: 20, per2: 1,  exp_a: 1'b1, exp_b: 1'b1}; // 50>1 ; 15>1
      vecs[7] = '{per1: 0,  per2: 1,  exp_a: 1'b1, exp_b: 1'b1}; // both stuck, hold
      vecs[8] = '{per1: 0,  per2: 20, exp_a: 1'b0, exp_b: 1'b0}; // 0<50 ; 0<15
      vecs[9] = '{per1: 4,  per2: 6,  exp_a: 1'b1, exp_b: 1'b0}; // 250>167 ; 15=15 hold 0

      // Reset held 5 clk.
      step(5);
      chk("rst_color_a", {1'b0, color_a}, 2'b00);
      chk("rst_color_b", {1'b0, color_b}, 2'b00);
      chk("rst_scale_a", scale_a, 2'b00);
      chk("rst_scale_b", scale_b, 2'b00);

      // Release; scale follows on the next clock edge, not before.
      rst = 1'b0;
      set_rates(vecs[0].per1, vecs[0].per2);
      chk("scale_pre_edge", scale_a, 2'b00);
      step(1);
      chk("scale_a_run", scale_a, 2'b11);
      chk("scale_b_run", scale_b, 2'b10);

      // Window 0: color must not flip before the window-end edge.
      step(GATE - 2);
      chk("w0_before_end", {1'b0, color_a}, 2'b00);
      step(1);

      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            set_rates(vecs[i].per1, vecs[i].per2);
            step(GATE);
         end
         chk($sformatf("vec%0d_color_a", i), {1'b0, color_a}, {1'b0, vecs[i].exp_a});
         chk($sformatf("vec%0d_color_b", i), {1'b0, color_b}, {1'b0, vecs[i].exp_b});
      end
      chk("scale_a_held", scale_a, 2'b11);

      // Reset half way through a window with channel 1 faster.
      set_rates(20, 40);
      step(500);
      rst = 1'b1;
      step(3);
      chk("midrst_color_a", {1'b0, color_a}, 2'b00);
      chk("midrst_color_b", {1'b0, color_b}, 2'b00);
      chk("midrst_scale_a", scale_a, 2'b00);
      rst = 1'b0;
      set_rates(20, 40);
      step(GATE / 2);
      chk("postrst_half", {1'b0, color_a}, 2'b00);
      step(GATE / 2 - 1);
      chk("postrst_w999", {1'b0, color_a}, 2'b00);
      step(1);
      chk("postrst_w1000_a", {1'b0, color_a}, 2'b01);
      chk("postrst_w1000_b", {1'b0, color_b}, 2'b00);
      chk("postrst_scale_a", scale_a, 2'b11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
